engine_dispatcher: RTL
======================

ENGINE_DISPATCHER -- requirements
Module: engine_dispatcher

Interface
REQ-001 The block SHALL have parameter NUM_ENGINES, default 4, meaning the number of Mandelbrot engines served (1..8).
REQ-002 The block SHALL have parameter X_SIZE, default 640, meaning pixels per line.
REQ-003 The block SHALL have parameter DEPTH_W, default 10, meaning the iteration-depth result width.
REQ-004 The block SHALL have port out_stream_aclk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port periph_resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port line_start, input, 1 bit: request to compute one line.
REQ-007 The block SHALL have port line_y, input, 9 bits: the line index, sampled when line_start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: a line is in progress.
REQ-009 The block SHALL have port line_done, output, 1 bit: one-cycle pulse when the line is complete.
REQ-010 The block SHALL have port eng_start, output, NUM_ENGINES bits: one-hot, one-cycle job launch.
REQ-011 The block SHALL have port eng_x, output, 10 bits: the pixel x for the launched job.
REQ-012 The block SHALL have port eng_y, output, 9 bits: the latched line_y.
REQ-013 The block SHALL have port eng_done, input, NUM_ENGINES bits: per-engine one-cycle completion pulse.
REQ-014 The block SHALL have port eng_depth, input, NUM_ENGINES*DEPTH_W bits: per-engine depth, valid while that engine's eng_done is high.
REQ-015 The block SHALL have port we_out, output, 1 bit: line-buffer write strobe.
REQ-016 The block SHALL have port addr_out, output, 10 bits: line-buffer write address (pixel x).
REQ-017 The block SHALL have port depth_out, output, DEPTH_W bits: line-buffer write data.
REQ-018 The block SHALL have port line_cycles, output, 32 bits: see Configuration.

Function
REQ-019 The state machine SHALL have states IDLE, RUN and FINISH.
REQ-020 IDLE->RUN SHALL occur on line_start; line_y is latched to eng_y, and the dispatch and write counters are cleared.
REQ-021 line_start SHALL be ignored in RUN and FINISH.
REQ-022 Each engine SHALL carry a busy flag, a pending-result register (x, depth) and a pending-valid flag.
REQ-023 An engine SHALL be free when it is not busy and its pending-valid flag is clear.
REQ-024 In RUN, while the dispatched count is below X_SIZE, the block SHALL start at most one free engine per cycle, chosen round-robin from the index after the last one started.
REQ-025 On each dispatch the block SHALL drive eng_x = dispatched count, assert that engine's eng_start bit, set its busy flag and increment the dispatched count.
REQ-026 The first eng_start SHALL appear in the cycle after line_start is accepted.
REQ-027 On eng_done[i] while busy[i], the block SHALL capture depth and x into slot i, set pending-valid[i] and clear busy[i].
REQ-028 eng_done[i] while busy[i] is low SHALL be ignored.
REQ-029 Simultaneous eng_done pulses from several engines SHALL all be captured in the same cycle.
REQ-030 Writeback SHALL grant one pending slot per cycle, round-robin; the grant drives we_out=1 with that slot's addr_out and depth_out, clears its pending-valid flag and increments the write count.
REQ-031 Capture-to-we_out latency SHALL be at least 1 cycle; with a single pending slot it SHALL be exactly 1 cycle.
REQ-032 A freed engine SHALL be dispatchable in the cycle after its slot is written back.
REQ-033 RUN->FINISH SHALL occur when the write count reaches X_SIZE.
REQ-034 FINISH SHALL pulse line_done for 1 cycle and then return to IDLE.
REQ-035 busy SHALL be 1 in RUN and FINISH, and 0 in IDLE.
REQ-036 eng_x values SHALL wrap never: dispatch stops at X_SIZE-1.
REQ-037 Each x SHALL be written exactly once per line, in any order.

Reset
REQ-038 On periph_resetn low, the block SHALL immediately (asynchronously) enter IDLE, including mid-line.
REQ-039 On reset, all busy and pending flags, counters and round-robin pointers SHALL be cleared.
REQ-040 On reset, the outputs SHALL be: busy=0, line_done=0, eng_start=0, eng_x=0, eng_y=0, we_out=0, addr_out=0, depth_out=0, line_cycles=0.
REQ-041 Engine results arriving after reset SHALL be ignored.

Configuration
REQ-042 With macro DISPATCH_PERF_EN defined, a 32-bit counter SHALL clear on line_start acceptance, increment each cycle in RUN, and load into line_cycles when line_done pulses (held until the next line_done or reset).
REQ-043 Without DISPATCH_PERF_EN, line_cycles SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-044 NUM_ENGINES=4 with eng_done 3 cycles after each start, line_start -> X_SIZE writes with addr 0..639 each exactly once; line_done pulses once; busy is 0 afterward.
REQ-045 All 4 engines pulse eng_done in the same cycle with depths 5, 6, 7, 8 -> 4 consecutive we_out cycles carrying those depths with the matching x values; no data is lost.
REQ-046 line_start is reasserted mid-line with line_y=9 -> ignored; eng_y keeps its original value; the write count is unaffected.
REQ-047 eng_done[2] is pulsed while engine 2 is idle -> no we_out and no counter change.
REQ-048 periph_resetn is dropped after 100 dispatches -> all outputs go 0 asynchronously; a new line_start then yields x starting at 0.
REQ-049 With DISPATCH_PERF_EN defined, NUM_ENGINES=1 and a fixed 1-cycle engine -> line_cycles equals the measured RUN cycle count; without the macro, line_cycles=0.

Source files
------------

// File: rtl/engine_dispatcher.sv
// engine_dispatcher: spreads the pixels of one line over NUM_ENGINES Mandelbrot
// engines and funnels their depth results into a line-buffer write port.
// Each engine owns one result slot; an engine is reused only after its slot
// has been written back.
// Optional build macro DISPATCH_PERF_EN adds a per-line RUN cycle counter on
// line_cycles; without it line_cycles is tied to 0.
module engine_dispatcher #(
    parameter int unsigned NUM_ENGINES = 4,
    parameter int unsigned X_SIZE      = 640,
    parameter int unsigned DEPTH_W     = 10
) (
    input  logic                           out_stream_aclk,
    input  logic                           periph_resetn,
    input  logic                           line_start,
    input  logic [8:0]                     line_y,
    output logic                           busy,
    output logic                           line_done,
    output logic [NUM_ENGINES-1:0]         eng_start,
    output logic [9:0]                     eng_x,
    output logic [8:0]                     eng_y,
    input  logic [NUM_ENGINES-1:0]         eng_done,
    input  logic [NUM_ENGINES*DEPTH_W-1:0] eng_depth,
    output logic                           we_out,
    output logic [9:0]                     addr_out,
    output logic [DEPTH_W-1:0]             depth_out,
    output logic [31:0]                    line_cycles
);

    localparam int unsigned CNT_W = $clog2(X_SIZE + 1);
    localparam int unsigned PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StFinish = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [8:0]             eng_y_q, eng_y_d;
    logic [CNT_W-1:0]       disp_cnt_q, disp_cnt_d;
    logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
    logic [PTR_W-1:0]       disp_ptr_q, disp_ptr_d;
    logic [PTR_W-1:0]       wb_ptr_q, wb_ptr_d;

    logic [NUM_ENGINES-1:0] eng_busy_q;
    logic [NUM_ENGINES-1:0] pend_vld_q;
    logic [9:0]             pend_x_q     [NUM_ENGINES];
    logic [DEPTH_W-1:0]     pend_depth_q [NUM_ENGINES];

    logic [NUM_ENGINES-1:0] eng_free;
    logic                   disp_en, disp_found, disp_go;
    logic [PTR_W-1:0]       disp_idx;
    logic                   wb_found;
    logic [PTR_W-1:0]       wb_idx;

    // Index 'off' positions after 'base', wrapping at NUM_ENGINES.
    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base,
                                                input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_ENGINES) begin
            sum = sum - NUM_ENGINES;
        end
        return PTR_W'(sum);
    endfunction

    assign eng_free = ~eng_busy_q & ~pend_vld_q;
    assign disp_en  = (state_q == StRun) && (disp_cnt_q < CNT_W'(X_SIZE));
    assign disp_go  = disp_en && disp_found;

    // Round-robin search for the next free engine, starting after the last one launched.
    always_comb begin
        disp_found = 1'b0;
        disp_idx   = '0;
        for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
            if (!disp_found && eng_free[rr_idx(disp_ptr_q, k)]) begin
                disp_found = 1'b1;
                disp_idx   = rr_idx(disp_ptr_q, k);
            end
        end
    end

    // Round-robin search for the next pending result slot to write back.
    always_comb begin
        wb_found = 1'b0;
        wb_idx   = '0;
        for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
            if (!wb_found && pend_vld_q[rr_idx(wb_ptr_q, k)]) begin
                wb_found = 1'b1;
                wb_idx   = rr_idx(wb_ptr_q, k);
            end
        end
    end

    // Launch strobe and line-buffer write port, driven from registered state only.
    always_comb begin
        eng_start = '0;
        if (disp_go) begin
            eng_start[disp_idx] = 1'b1;
        end
        we_out    = wb_found;
        addr_out  = wb_found ? pend_x_q[wb_idx] : '0;
        depth_out = wb_found ? pend_depth_q[wb_idx] : '0;
    end

    assign eng_x     = 10'(disp_cnt_q);
    assign eng_y     = eng_y_q;
    assign busy      = (state_q != StIdle);
    assign line_done = (state_q == StFinish);

    // Line FSM, dispatch/write counters and round-robin pointers.
    always_comb begin
        state_d    = state_q;
        eng_y_d    = eng_y_q;
        disp_cnt_d = disp_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        disp_ptr_d = disp_go ? rr_idx(disp_idx, 1) : disp_ptr_q;
        wb_ptr_d   = wb_found ? rr_idx(wb_idx, 1) : wb_ptr_q;
        case (state_q)
            StIdle: begin
                if (line_start) begin
                    state_d    = StRun;
                    eng_y_d    = line_y;
                    disp_cnt_d = '0;
                    wr_cnt_d   = '0;
                end
            end
            StRun: begin
                if (disp_go) begin
                    disp_cnt_d = disp_cnt_q + CNT_W'(1);
                end
                if (wb_found) begin
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                end
                if (wr_cnt_d == CNT_W'(X_SIZE)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_q    <= StIdle;
            eng_y_q    <= '0;
            disp_cnt_q <= '0;
            wr_cnt_q   <= '0;
            disp_ptr_q <= '0;
            wb_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            eng_y_q    <= eng_y_d;
            disp_cnt_q <= disp_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            disp_ptr_q <= disp_ptr_d;
            wb_ptr_q   <= wb_ptr_d;
        end
    end

    // Per-engine busy flag and result slot; x is parked in the slot at launch since
    // the slot is guaranteed empty while the engine is free.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            eng_busy_q <= '0;
            pend_vld_q <= '0;
            for (int i = 0; i < NUM_ENGINES; i++) begin
                pend_x_q[i]     <= '0;
                pend_depth_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
                if (disp_go && (disp_idx == PTR_W'(i))) begin
                    eng_busy_q[i] <= 1'b1;
                    pend_x_q[i]   <= eng_x;
                end else if (eng_done[i] && eng_busy_q[i]) begin
                    eng_busy_q[i]   <= 1'b0;
                    pend_vld_q[i]   <= 1'b1;
                    pend_depth_q[i] <= eng_depth[i*DEPTH_W +: DEPTH_W];
                end
                if (wb_found && (wb_idx == PTR_W'(i))) begin
                    pend_vld_q[i] <= 1'b0;
                end
            end
        end
    end

`ifdef DISPATCH_PERF_EN
    logic [31:0] cyc_cnt_q;
    logic [31:0] line_cycles_q;

    // Count RUN cycles of the current line and publish the total at line_done.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            cyc_cnt_q     <= '0;
            line_cycles_q <= '0;
        end else begin
            if ((state_q == StIdle) && line_start) begin
                cyc_cnt_q <= '0;
            end else if (state_q == StRun) begin
                cyc_cnt_q <= cyc_cnt_q + 32'd1;
            end
            if (state_q == StFinish) begin
                line_cycles_q <= cyc_cnt_q;
            end
        end
    end

    assign line_cycles = line_cycles_q;
`else
    assign line_cycles = 32'd0;
`endif

endmodule
